// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the line buffer and the 3x3 convolution stage.
package conv_pkg;

   localparam int unsigned PIXEL_NB    = 8;
   localparam int unsigned KERNEL_SIZE = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EMIT_TOP = 2'd1,
      EMIT_MID = 2'd2,
      EMIT_BOT = 2'd3
   } lb_state_e;

endpackage : conv_pkg

// File: rtl/line_mem.sv
// One image-row memory: async read, sync write, contents survive reset.
module line_mem #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_W     = 8
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_W-1:0]     rdata_o
);

   localparam int unsigned IDX_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   logic [DATA_W-1:0] mem_q [IMG_WIDTH];

   // Out-of-range columns never occur in practice; guarding keeps the array index in bounds.
   always_ff @(posedge clk_i) begin
      if (we_i && (32'(waddr_i) < IMG_WIDTH)) begin
         mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
      end
   end

   assign rdata_o = (32'(raddr_i) < IMG_WIDTH) ? mem_q[raddr_i[IDX_W-1:0]] : '0;

endmodule : line_mem

// File: rtl/line_buffer_3x3.sv
// Raster pixel stream in, vertical 3-pixel columns (rows r-2, r-1, r) out as three beats.
module line_buffer_3x3
   import conv_pkg::*;
#(
   parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned PIXEL_W            = conv_pkg::PIXEL_NB,
   parameter int unsigned IMG_WIDTH          = 640,
   parameter int unsigned ADDR_WIDTH         = 12
) (
   input  logic                            s00_axis_aclk,
   input  logic                            s00_axis_areset,
   input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                            s00_axis_tvalid,
   output logic                            s00_axis_tready,
   input  logic                            s00_axis_tlast,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                            m00_axis_tvalid,
   input  logic                            m00_axis_tready,
   output logic                            m00_axis_tlast
);

   localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);

   lb_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] col_q, col_d;
   logic [1:0]            row_q, row_d;
   logic [PIXEL_W-1:0]    mid_q, mid_d;
   logic [PIXEL_W-1:0]    bot_q, bot_d;
   logic                  last_q, last_d;
   logic [PIXEL_W-1:0]    tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;
   logic                  tready_q, tready_d;

   logic                  accept_c;
   logic                  mem_we_c;
   logic [PIXEL_W-1:0]    pix_c;
   logic [PIXEL_W-1:0]    line0_rd_c;
   logic [PIXEL_W-1:0]    line1_rd_c;
   logic                  unused_c;

   assign pix_c    = s00_axis_tdata[PIXEL_W-1:0];
   assign accept_c = s00_axis_tvalid & tready_q;
   assign unused_c = ^{s00_axis_tstrb, s00_axis_tdata[C_AXIS_TDATA_WIDTH-1:PIXEL_W]};

   // line0 holds row r-2, line1 row r-1; each accepted pixel shifts the column down one row.
   line_mem #(.IMG_WIDTH(IMG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_W(PIXEL_W)) u_line0 (
      .clk_i   (s00_axis_aclk),
      .we_i    (mem_we_c),
      .waddr_i (col_q),
      .wdata_i (line1_rd_c),
      .raddr_i (col_q),
      .rdata_o (line0_rd_c)
   );

   line_mem #(.IMG_WIDTH(IMG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_W(PIXEL_W)) u_line1 (
      .clk_i   (s00_axis_aclk),
      .we_i    (mem_we_c),
      .waddr_i (col_q),
      .wdata_i (pix_c),
      .raddr_i (col_q),
      .rdata_o (line1_rd_c)
   );

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         state_q  <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         mid_q    <= '0;
         bot_q    <= '0;
         last_q   <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         mid_q    <= mid_d;
         bot_q    <= bot_d;
         last_q   <= last_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tready_q <= tready_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      mid_d    = mid_q;
      bot_d    = bot_q;
      last_d   = last_q;
      tdata_d  = tdata_q;
      mem_we_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               mem_we_c = ~s00_axis_areset;
               if (s00_axis_tlast) begin
                  col_d = '0;
                  row_d = '0;
               end else if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = (row_q == 2'd2) ? 2'd2 : row_q + 2'd1;
               end else begin
                  col_d = col_q + ADDR_WIDTH'(1);
               end
               if (row_q == 2'd2) begin
                  tdata_d = line0_rd_c;
                  mid_d   = line1_rd_c;
                  bot_d   = pix_c;
                  last_d  = s00_axis_tlast;
                  state_d = EMIT_TOP;
               end
            end
         end
         EMIT_TOP: begin
            if (m00_axis_tready) begin
               tdata_d = mid_q;
               state_d = EMIT_MID;
            end
         end
         EMIT_MID: begin
            if (m00_axis_tready) begin
               tdata_d = bot_q;
               state_d = EMIT_BOT;
            end
         end
         EMIT_BOT: begin
            if (m00_axis_tready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      tready_d = (state_d == IDLE);
      tvalid_d = (state_d != IDLE);
      tlast_d  = (state_d == EMIT_BOT) & last_d;
   end

   assign s00_axis_tready = tready_q;
   assign m00_axis_tdata  = C_AXIS_TDATA_WIDTH'(tdata_q);
   assign m00_axis_tstrb  = '1;
   assign m00_axis_tvalid = tvalid_q;
   assign m00_axis_tlast  = tlast_q;

endmodule : line_buffer_3x3

// File: tb/tb_line_buffer_3x3.sv
// Directed bench for line_buffer_3x3 with a 4-pixel-wide image, pixel = 10*row + col.
module tb_line_buffer_3x3;

   localparam int unsigned DW = 32;
   localparam int unsigned W  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   s_tdata;
   logic [DW/8-1:0] s_tstrb;
   logic            s_tvalid;
   logic            s_tready;
   logic            s_tlast;
   logic [DW-1:0]   m_tdata;
   logic [DW/8-1:0] m_tstrb;
   logic            m_tvalid;
   logic            m_tready;
   logic            m_tlast;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int got_q[$];
   int exp_q[$];

   line_buffer_3x3 #(
      .C_AXIS_TDATA_WIDTH (DW),
      .PIXEL_W            (8),
      .IMG_WIDTH          (W),
      .ADDR_WIDTH         (12)
   ) dut (
      .s00_axis_aclk   (clk),
      .s00_axis_areset (rst),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tstrb  (s_tstrb),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tready (s_tready),
      .s00_axis_tlast  (s_tlast),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tready (m_tready),
      .m00_axis_tlast  (m_tlast)
   );

   always #5 clk = ~clk;

   // Beats are encoded as data + 256*tlast; a handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (!rst && m_tvalid && m_tready)
         got_q.push_back(int'(m_tdata[7:0]) + (m_tlast ? 256 : 0));
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input int v, input bit last);
      int n;
      s_tdata  = DW'(v);
      s_tvalid = 1'b1;
      s_tlast  = last;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!s_tready && n < 200);
      if (!s_tready) begin
         total_cnt++;
         $display("FAIL send_timeout pixel=%0d tready never rose", v);
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_rows(input int r0, input int r1, input int last_pix);
      for (int r = r0; r <= r1; r++)
         for (int c = 0; c < int'(W); c++)
            send(10 * r + c, (10 * r + c) == last_pix);
   endtask

   task automatic build_expected(input int rows, input bit last_on_end);
      exp_q.delete();
      for (int r = 2; r < rows; r++)
         for (int c = 0; c < int'(W); c++) begin
            exp_q.push_back(10 * (r - 2) + c);
            exp_q.push_back(10 * (r - 1) + c);
            exp_q.push_back(10 * r + c +
               ((last_on_end && r == rows - 1 && c == int'(W) - 1) ? 256 : 0));
         end
   endtask

   task automatic drain();
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = DW'(99);
      s_tlast  = 1'b0;
      s_tstrb  = '1;
      m_tready = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total_cnt++;
         if ({s_tready, m_tvalid, m_tdata} !== {1'b0, 1'b0, 32'd0})
            $display("FAIL reset_hold cyc=%0d tready=%b tvalid=%b tdata=%0d want 0/0/0",
                     i, s_tready, m_tvalid, m_tdata);
         else pass_cnt++;
         if (i < 2) @(posedge clk);
      end
      @(posedge clk); #1;
      rst      = 1'b0;
      s_tvalid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (s_tready !== 1'b0)
         $display("FAIL reset_release_early tready=%b want 0", s_tready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (s_tready !== 1'b1)
         $display("FAIL reset_release tready=%b want 1", s_tready);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_frame3();
      got_q.delete();
      send_rows(0, 1, -1);
      drain();
      total_cnt++;
      if (got_q.size() != 0 || m_tvalid !== 1'b0)
         $display("FAIL frame3_quiet beats=%0d tvalid=%b want 0/0", got_q.size(), m_tvalid);
      else pass_cnt++;
      send(20, 1'b0);
      total_cnt++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'd0)
         $display("FAIL frame3_latency tvalid=%b tdata=%0d want 1/0", m_tvalid, m_tdata);
      else pass_cnt++;
      for (int c = 1; c < int'(W); c++) send(20 + c, c == int'(W) - 1);
      drain();
      build_expected(3, 1'b1);
      total_cnt++;
      if (got_q.size() != exp_q.size())
         $display("FAIL frame3_count got=%0d want=%0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL frame3_beat%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      got_q.delete();
      fork
         send_rows(0, 2, 23);
         begin
            int n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(m_tvalid && m_tdata == 32'd1) && n < 400);
            if (n >= 400) begin
               total_cnt++;
               $display("FAIL bp_trigger never saw top beat 1");
            end
            @(posedge clk); #1;
            m_tready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               total_cnt++;
               if ({m_tvalid, m_tdata, s_tready} !== {1'b1, 32'd11, 1'b0})
                  $display("FAIL bp_hold cyc=%0d tvalid=%b tdata=%0d s_tready=%b want 1/11/0",
                           i, m_tvalid, m_tdata, s_tready);
               else pass_cnt++;
            end
            @(posedge clk); #1;
            m_tready = 1'b1;
         end
      join
      drain();
      build_expected(3, 1'b1);
      total_cnt++;
      if (got_q.size() != exp_q.size())
         $display("FAIL bp_count got=%0d want=%0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL bp_beat%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_early_tlast();
      got_q.delete();
      send_rows(0, 0, -1);
      send(10, 1'b0);
      send(11, 1'b0);
      send(12, 1'b1);
      drain();
      total_cnt++;
      if (got_q.size() != 0)
         $display("FAIL early_tlast_beats got=%0d want=0", got_q.size());
      else pass_cnt++;
      send_rows(0, 1, -1);
      drain();
      total_cnt++;
      if (got_q.size() != 0)
         $display("FAIL early_next_quiet got=%0d want=0", got_q.size());
      else pass_cnt++;
      send_rows(2, 2, 23);
      drain();
      build_expected(3, 1'b1);
      total_cnt++;
      if (got_q.size() != exp_q.size())
         $display("FAIL early_count got=%0d want=%0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL early_beat%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_four_rows();
      got_q.delete();
      send_rows(0, 3, 33);
      drain();
      build_expected(4, 1'b1);
      total_cnt++;
      if (got_q.size() != exp_q.size())
         $display("FAIL rows4_count got=%0d want=%0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL rows4_beat%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      send_rows(0, 1, -1);
      send(20, 1'b0);
      @(posedge clk); #1;
      total_cnt++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'd10)
         $display("FAIL rstmid_pre tvalid=%b tdata=%0d want 1/10", m_tvalid, m_tdata);
      else pass_cnt++;
      rst = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if ({m_tvalid, m_tlast, s_tready} !== 3'b000)
         $display("FAIL rstmid_post tvalid=%b tlast=%b tready=%b want 0/0/0",
                  m_tvalid, m_tlast, s_tready);
      else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
      got_q.delete();
      send_rows(0, 2, 23);
      drain();
      build_expected(3, 1'b1);
      total_cnt++;
      if (got_q.size() != exp_q.size())
         $display("FAIL rstmid_count got=%0d want=%0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL rstmid_beat%0d got=%0d want=%0d", i, got_q[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_frame3();
      test_backpressure();
      test_early_tlast();
      test_four_rows();
      test_reset_mid();
      total_cnt++;
      if (m_tstrb !== 4'hF)
         $display("FAIL tstrb got=%h want=f", m_tstrb);
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_line_buffer_3x3
